lsu: RTL and testbench
======================

# lsu

Parametrised, multi-cycle load/store unit for the tiny-riscv core. It sits between decode/execute and the data-memory port. It computes the effective address, issues byte-enabled memory requests through a valid/ready handshake, and waits for load data. It then returns sign- or zero-extended load results, or a fault code for misaligned accesses and memory time-outs. It supports the full RV32I load/store set plus LUI pass-through, with one transaction in flight.

## Interface
Parameters:
- XLEN, 32: data and address width; must be 32 or 64.
- TIMEOUT, 255: maximum number of cycles to wait for d_rsp_valid before a bus-error fault; minimum 1.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  operation offered.
- req_ready  out  1  unit idle and able to accept.
- ls_op  in  ls_op_t  operation (LUI, LB, LH, LW, LBU, LHU, SB, SH, SW).
- rs1_data  in  XLEN  base address.
- rs2_data  in  XLEN  store data.
- imm  in  XLEN  sign-extended offset; for LUI, the upper immediate.
- d_req_valid  out  1  memory request valid.
- d_req_ready  in  1  memory accepts the request.
- d_we  out  1  1 = store.
- d_addr  out  XLEN  word-aligned address (low log2(XLEN/8) bits are 0).
- d_be  out  XLEN/8  byte enables.
- d_wr_data  out  XLEN  store data replicated into the target lane.
- d_rsp_valid  in  1  load data valid.
- d_rd_data  in  XLEN  load data word.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  XLEN  load/LUI result; 0 for stores and faults.
- resp_fault  out  ls_fault_t  NONE, MISALIGNED or BUS_TIMEOUT.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register the op, ea=rs1_data+imm (modulo 2^XLEN), rs2_data and the lane offset ea[log2(XLEN/8)-1:0].
- IDLE transitions:
  - LUI: go to RESP with result=imm.
  - Misaligned access: go to RESP with MISALIGNED, and issue no memory access. Misaligned means a halfword with ea[0]=1, or a word with ea[1:0]≠0.
  - Otherwise: go to REQ.
- REQ:
  - d_req_valid=1; address, be, we and wr_data are held stable until d_req_ready.
  - On handshake, a store goes to RESP and a load goes to WAIT with the timeout counter cleared.
- WAIT:
  - The counter increments every cycle.
  - On d_rsp_valid, extract the lane and sign-extend (LB/LH/LW on XLEN=64) or zero-extend (LBU/LHU), then go to RESP.
  - When the counter reaches TIMEOUT without d_rsp_valid, go to RESP with BUS_TIMEOUT.
  - If d_rsp_valid arrives in the same cycle the counter reaches TIMEOUT, the data wins.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE.
- Byte enables:
  - SB/LB: one bit at the lane offset.
  - SH/LH: two bits.
  - SW/LW: four bits.
- d_rsp_valid seen outside WAIT is ignored.
- d_req_ready seen outside REQ is ignored.

## Timing
- Reset, asynchronous on rst_n=0:
  - The FSM goes to IDLE.
  - req_ready=1.
  - d_req_valid=0, d_we=0, resp_valid=0.
  - d_addr, d_be, d_wr_data, resp_data are 0; resp_fault=NONE.
  - The timeout counter is 0.
- Reset mid-transaction abandons the transaction, and no resp_valid is produced.
- req_ready depends only on the state, never combinationally on req_valid.
- Store latency, request accepted at cycle 0:
  - d_req_valid is asserted at cycle 1.
  - With d_req_ready=1 at cycle 1, resp_valid is asserted at cycle 2.
- Load latency: resp_valid follows d_rsp_valid by one cycle.
- Misaligned and LUI operations: resp_valid at cycle 1.
- The next request can be accepted in the cycle after resp_valid.
- All outputs are registered.

## Structure
- Shared defines.svh:
  - Extend ls_op_t with SB, SH and SW.
  - Add ls_fault_t {NONE, MISALIGNED, BUS_TIMEOUT}.
  - Add the lsu_state_t enum.
- Sub-module ls_align is purely combinational. It takes op, lane offset, rs2_data and d_rd_data, and produces d_be, lane-replicated write data and the extended load result.
- The LSU top holds the FSM, the registers and the timeout counter, sized $clog2(TIMEOUT+1).

## Test plan
- LW with rs1=0x1000, imm=4, mem[0x1004]=0xDEADBEEF:
  - Required: d_addr=0x1004, d_be=4'b1111, resp_data=0xDEADBEEF, fault NONE.
- LB and LBU at ea=0x1003 with word data 0x80112233:
  - LB returns 0xFFFFFF80; LBU returns 0x00000080; d_be=4'b1000 in both cases.
- SH with rs2=0x0000ABCD at ea=0x2002:
  - Required: d_be=4'b1100, d_wr_data[31:16]=0xABCD, d_we=1.
  - d_req_ready is held low for 3 cycles; the request must stay stable throughout.
- LW at ea=0x1001:
  - Required: no d_req_valid, resp_valid at cycle 1 with MISALIGNED and resp_data=0.
- Load with d_rsp_valid never asserted, TIMEOUT=4:
  - Required: BUS_TIMEOUT pulse 4 cycles after entering WAIT.
  - Repeat with d_rsp_valid on the 4th cycle: data must be returned, not a fault.
- rst_n pulsed low while in WAIT:
  - Required: all outputs reach their reset values immediately, no resp_valid, and req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and decode helpers for the load/store unit
package lsu_pkg;

   typedef enum logic [3:0] {
      OP_LUI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
   } ls_op_t;

   typedef enum logic [1:0] {
      FAULT_NONE, FAULT_MISALIGNED, FAULT_BUS_TIMEOUT
   } ls_fault_t;

   typedef enum logic [1:0] {
      S_IDLE, S_REQ, S_WAIT, S_RESP
   } lsu_state_t;

   function automatic logic is_store(input ls_op_t op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   // Only halfword and word accesses carry alignment constraints.
   function automatic logic is_misaligned(input ls_op_t op, input logic [1:0] lo);
      case (op)
         OP_LH, OP_LHU, OP_SH: return lo[0];
         OP_LW, OP_SW:         return |lo;
         default:              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable, store lane replication and load extraction
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int OFFW = $clog2(XLEN/8)
) (
   input  ls_op_t            i_op,
   input  logic [OFFW-1:0]   i_off,
   input  logic [XLEN-1:0]   i_rs2_data,
   input  logic [XLEN-1:0]   i_rd_data,
   output logic [XLEN/8-1:0] o_be,
   output logic [XLEN-1:0]   o_wr_data,
   output logic [XLEN-1:0]   o_ld_data
);

   localparam int BEW = XLEN/8;

   logic [XLEN-1:0] w_lane;

   assign w_lane = i_rd_data >> {i_off, 3'b000};

   always_comb begin
      o_be      = '0;
      o_wr_data = '0;
      o_ld_data = '0;
      case (i_op)
         OP_LB, OP_LBU, OP_SB: o_be = BEW'(1)  << i_off;
         OP_LH, OP_LHU, OP_SH: o_be = BEW'(3)  << i_off;
         OP_LW, OP_SW:         o_be = BEW'(15) << i_off;
         default:              o_be = '0;
      endcase
      // Replicating across every lane lets the byte enables pick the target.
      case (i_op)
         OP_SB:   o_wr_data = {BEW{i_rs2_data[7:0]}};
         OP_SH:   o_wr_data = {(BEW/2){i_rs2_data[15:0]}};
         OP_SW:   o_wr_data = {(BEW/4){i_rs2_data[31:0]}};
         default: o_wr_data = '0;
      endcase
      case (i_op)
         OP_LB:   o_ld_data = XLEN'($signed(w_lane[7:0]));
         OP_LH:   o_ld_data = XLEN'($signed(w_lane[15:0]));
         OP_LW:   o_ld_data = XLEN'($signed(w_lane[31:0]));
         OP_LBU:  o_ld_data = XLEN'(w_lane[7:0]);
         OP_LHU:  o_ld_data = XLEN'(w_lane[15:0]);
         default: o_ld_data = '0;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - multi-cycle load/store unit with one transaction in flight
module lsu
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  ls_op_t            ls_op,
   input  logic [XLEN-1:0]   rs1_data,
   input  logic [XLEN-1:0]   rs2_data,
   input  logic [XLEN-1:0]   imm,
   output logic              d_req_valid,
   input  logic              d_req_ready,
   output logic              d_we,
   output logic [XLEN-1:0]   d_addr,
   output logic [XLEN/8-1:0] d_be,
   output logic [XLEN-1:0]   d_wr_data,
   input  logic              d_rsp_valid,
   input  logic [XLEN-1:0]   d_rd_data,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_data,
   output ls_fault_t         resp_fault
);

   localparam int BEW  = XLEN/8;
   localparam int OFFW = $clog2(BEW);
   localparam int CW   = $clog2(TIMEOUT+1);

   lsu_state_t        r_state, w_state_nx;
   ls_op_t            r_op;
   logic [OFFW-1:0]   r_off;
   logic [CW-1:0]     r_cnt, w_cnt_nx, w_cnt_inc;
   logic              r_req_ready, r_d_req_valid, r_d_we, r_resp_valid;
   logic [XLEN-1:0]   r_d_addr, r_d_wr_data, r_resp_data;
   logic [BEW-1:0]    r_d_be;
   ls_fault_t         r_resp_fault;

   logic [XLEN-1:0]   w_ea, w_wr_data, w_ld_data, w_resp_data_nx;
   logic [BEW-1:0]    w_be;
   ls_op_t            w_al_op;
   logic [OFFW-1:0]   w_al_off;
   logic              w_misaligned, w_accept;
   ls_fault_t         w_fault_nx;

   assign w_ea         = rs1_data + imm;
   assign w_accept     = (r_state == S_IDLE) && req_valid;
   assign w_misaligned = is_misaligned(ls_op, w_ea[1:0]);
   assign w_cnt_inc    = r_cnt + CW'(1);

   // The aligner sees the incoming request in IDLE and the held op afterwards.
   assign w_al_op  = (r_state == S_IDLE) ? ls_op : r_op;
   assign w_al_off = (r_state == S_IDLE) ? w_ea[OFFW-1:0] : r_off;

   lsu_align #(.XLEN(XLEN), .OFFW(OFFW)) u_align (
      .i_op       (w_al_op),
      .i_off      (w_al_off),
      .i_rs2_data (rs2_data),
      .i_rd_data  (d_rd_data),
      .o_be       (w_be),
      .o_wr_data  (w_wr_data),
      .o_ld_data  (w_ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx     = r_state;
      w_cnt_nx       = r_cnt;
      w_resp_data_nx = '0;
      w_fault_nx     = FAULT_NONE;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (ls_op == OP_LUI) begin
                  w_state_nx     = S_RESP;
                  w_resp_data_nx = imm;
               end else if (w_misaligned) begin
                  w_state_nx = S_RESP;
                  w_fault_nx = FAULT_MISALIGNED;
               end else begin
                  w_state_nx = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (d_req_ready) begin
               if (r_d_we) begin
                  w_state_nx = S_RESP;
               end else begin
                  w_state_nx = S_WAIT;
                  w_cnt_nx   = '0;
               end
            end
         end
         S_WAIT: begin
            w_cnt_nx = w_cnt_inc;
            // Data arriving on the final allowed cycle still wins over the fault.
            if (d_rsp_valid) begin
               w_state_nx     = S_RESP;
               w_resp_data_nx = w_ld_data;
            end else if (w_cnt_inc == CW'(TIMEOUT)) begin
               w_state_nx = S_RESP;
               w_fault_nx = FAULT_BUS_TIMEOUT;
            end
         end
         S_RESP:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op          <= OP_LUI;
         r_off         <= '0;
         r_cnt         <= '0;
         r_req_ready   <= 1'b1;
         r_d_req_valid <= 1'b0;
         r_d_we        <= 1'b0;
         r_d_addr      <= '0;
         r_d_be        <= '0;
         r_d_wr_data   <= '0;
         r_resp_valid  <= 1'b0;
         r_resp_data   <= '0;
         r_resp_fault  <= FAULT_NONE;
      end else begin
         r_cnt         <= w_cnt_nx;
         r_req_ready   <= (w_state_nx == S_IDLE);
         r_d_req_valid <= (w_state_nx == S_REQ);
         r_resp_valid  <= (w_state_nx == S_RESP);
         r_resp_data   <= w_resp_data_nx;
         r_resp_fault  <= w_fault_nx;
         if (w_accept) begin
            r_op  <= ls_op;
            r_off <= w_ea[OFFW-1:0];
         end
         if (w_accept && (w_state_nx == S_REQ)) begin
            r_d_we      <= is_store(ls_op);
            r_d_addr    <= {w_ea[XLEN-1:OFFW], {OFFW{1'b0}}};
            r_d_be      <= w_be;
            r_d_wr_data <= w_wr_data;
         end
      end
   end

   assign req_ready   = r_req_ready;
   assign d_req_valid = r_d_req_valid;
   assign d_we        = r_d_we;
   assign d_addr      = r_d_addr;
   assign d_be        = r_d_be;
   assign d_wr_data   = r_d_wr_data;
   assign resp_valid  = r_resp_valid;
   assign resp_data   = r_resp_data;
   assign resp_fault  = r_resp_fault;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed bench for lsu with a transaction-level reference model
module tb_lsu;
   import lsu_pkg::*;

   localparam int XLEN    = 32;
   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   ls_op_t      ls_op = OP_LUI;
   logic [31:0] rs1_data = '0, rs2_data = '0, imm = '0;
   logic        d_req_valid, d_we;
   logic        d_req_ready = 1'b0;
   logic [31:0] d_addr, d_wr_data;
   logic [3:0]  d_be;
   logic        d_rsp_valid = 1'b0;
   logic [31:0] d_rd_data = '0;
   logic        resp_valid;
   logic [31:0] resp_data;
   ls_fault_t   resp_fault;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [31:0] data;
      ls_fault_t   fault;
   } exp_rsp_t;

   exp_rsp_t    exp_q[$];
   exp_rsp_t    cmp_e;
   logic        req_exp = 1'b0, exp_we = 1'b0;
   logic [31:0] exp_addr = '0, exp_wd = '0;
   logic [3:0]  exp_be = '0;
   logic [31:0] bus_mem [logic [31:0]];
   logic [31:0] mdl_mem [logic [31:0]];

   lsu #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .ls_op(ls_op), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
      .d_addr(d_addr), .d_be(d_be), .d_wr_data(d_wr_data),
      .d_rsp_valid(d_rsp_valid), .d_rd_data(d_rd_data),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] be_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
      return m;
   endfunction

   function automatic logic [31:0] mdl_rd(input logic [31:0] a);
      if (mdl_mem.exists(a)) return mdl_mem[a];
      return 32'h0;
   endfunction

   function automatic logic [31:0] bus_rd(input logic [31:0] a);
      if (bus_mem.exists(a)) return bus_mem[a];
      return 32'h0;
   endfunction

   function automatic int op_size(input ls_op_t op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1;
         OP_LH, OP_LHU, OP_SH: return 2;
         OP_LW, OP_SW:         return 4;
         default:              return 0;
      endcase
   endfunction

   task automatic mem_init(input logic [31:0] a, input logic [31:0] v);
      bus_mem[a] = v;
      mdl_mem[a] = v;
   endtask

   // Every cycle a request or response is on the bus it must match the model.
   always @(negedge clk) begin
      if (rst_n) begin
         if (d_req_valid) begin
            chk("req_expected", req_exp, 1);
            chk("d_addr", d_addr, exp_addr);
            chk("d_be", d_be, exp_be);
            chk("d_we", d_we, exp_we);
            chk("req_ready_busy", req_ready, 0);
            if (exp_we) chk("d_wr_data_lanes", d_wr_data & be_mask(d_be), exp_wd & be_mask(exp_be));
         end
         if (resp_valid) begin
            chk("resp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               cmp_e = exp_q.pop_front();
               chk("resp_data", resp_data, cmp_e.data);
               chk("resp_fault", resp_fault, cmp_e.fault);
            end
         end
      end
   end

   task automatic run_op(input ls_op_t op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] im, input int rdy_wait, input int rsp_wait,
                         input bit noise, input int exp_lat,
                         output logic [31:0] got_data, output ls_fault_t got_fault,
                         output logic [3:0] got_be, output logic [31:0] got_wd);
      logic [31:0] ea, w, hs_addr;
      int sz, off, lat, seen, wcnt;
      bit is_st, in_wait, done;
      exp_rsp_t e;
      ea = rs1 + im;
      sz = op_size(op);
      off = int'(ea[1:0]);
      is_st = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
      e.data = '0;
      e.fault = FAULT_NONE;
      req_exp = 1'b0;
      got_be = '0;
      got_wd = '0;
      hs_addr = '0;
      if (op == OP_LUI) begin
         e.data = im;
      end else if ((ea % sz) != 0) begin
         e.fault = FAULT_MISALIGNED;
      end else begin
         req_exp  = 1'b1;
         exp_addr = ea & ~32'h3;
         exp_be   = 4'((1 << sz) - 1) << off;
         exp_we   = is_st;
         exp_wd   = rs2 << (8 * off);
         if (is_st) begin
            mdl_mem[exp_addr] = (mdl_rd(exp_addr) & ~be_mask(exp_be)) | (exp_wd & be_mask(exp_be));
         end else if (rsp_wait < 1 || rsp_wait > TIMEOUT) begin
            e.fault = FAULT_BUS_TIMEOUT;
         end else begin
            w = mdl_rd(exp_addr) >> (8 * off);
            case (op)
               OP_LB:   e.data = {{24{w[7]}}, w[7:0]};
               OP_LBU:  e.data = {24'h0, w[7:0]};
               OP_LH:   e.data = {{16{w[15]}}, w[15:0]};
               OP_LHU:  e.data = {16'h0, w[15:0]};
               default: e.data = w;
            endcase
         end
      end
      exp_q.push_back(e);

      @(negedge clk);
      chk("req_ready_idle", req_ready, 1);
      d_req_ready = 1'b0;
      req_valid = 1'b1;
      ls_op = op;
      rs1_data = rs1;
      rs2_data = rs2;
      imm = im;
      lat = 0; seen = 0; wcnt = 0; in_wait = 0; done = 0;
      got_data = '0;
      got_fault = FAULT_NONE;
      while (!done && lat < 40) begin
         @(negedge clk);
         req_valid = 1'b0;
         ls_op = OP_SW;
         rs1_data = $urandom;
         rs2_data = $urandom;
         imm = $urandom;
         lat++;
         d_rsp_valid = 1'b0;
         d_rd_data = $urandom;
         if (resp_valid) begin
            done = 1;
            got_data = resp_data;
            got_fault = resp_fault;
         end else begin
            if (d_req_ready) begin
               d_req_ready = 1'b0;
               if (!exp_we) in_wait = 1;
            end else if (d_req_valid) begin
               got_be = d_be;
               got_wd = d_wr_data;
               if (seen >= rdy_wait) begin
                  d_req_ready = 1'b1;
                  hs_addr = d_addr;
                  if (d_we) bus_mem[d_addr] = (bus_rd(d_addr) & ~be_mask(d_be)) | (d_wr_data & be_mask(d_be));
               end else if (noise) begin
                  d_rsp_valid = 1'b1;
               end
               seen++;
            end
            if (in_wait) begin
               wcnt++;
               if (wcnt == rsp_wait) begin
                  d_rsp_valid = 1'b1;
                  d_rd_data = bus_rd(hs_addr);
               end
            end
         end
      end
      d_rsp_valid = 1'b0;
      d_req_ready = 1'b0;
      chk("resp_seen", done, 1);
      chk("latency", lat, exp_lat);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1);
      chk({tag, "_d_req_valid"}, d_req_valid, 0);
      chk({tag, "_d_we"}, d_we, 0);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_d_addr"}, d_addr, 0);
      chk({tag, "_d_be"}, d_be, 0);
      chk({tag, "_d_wr_data"}, d_wr_data, 0);
      chk({tag, "_resp_data"}, resp_data, 0);
      chk({tag, "_resp_fault"}, resp_fault, FAULT_NONE);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

   initial begin
      logic [31:0] gd, gw;
      ls_fault_t   gf;
      logic [3:0]  gb;
      mem_init(32'h1004, 32'hDEADBEEF);
      mem_init(32'h1000, 32'h80112233);
      repeat (2) @(negedge clk);
      check_reset("por");
      rst_n = 1'b1;

      run_op(OP_LW, 32'h1000, 32'h0, 32'h4, 0, 1, 0, 3, gd, gf, gb, gw);
      chk("lw_data", gd, 32'hDEADBEEF);
      chk("lw_be", gb, 4'b1111);
      run_op(OP_LB, 32'h1000, 32'h0, 32'h3, 2, 2, 1, 6, gd, gf, gb, gw);
      chk("lb_data", gd, 32'hFFFFFF80);
      chk("lb_be", gb, 4'b1000);
      run_op(OP_LBU, 32'h1000, 32'h0, 32'h3, 0, 1, 0, 3, gd, gf, gb, gw);
      chk("lbu_data", gd, 32'h00000080);
      chk("lbu_be", gb, 4'b1000);
      run_op(OP_SH, 32'h2000, 32'h0000ABCD, 32'h2, 3, 0, 0, 5, gd, gf, gb, gw);
      chk("sh_be", gb, 4'b1100);
      chk("sh_wd_hi", gw[31:16], 16'hABCD);
      chk("sh_data", gd, 32'h0);
      run_op(OP_LHU, 32'h2000, 32'h0, 32'h2, 0, 1, 0, 3, gd, gf, gb, gw);
      chk("lhu_data", gd, 32'h0000ABCD);
      run_op(OP_LH, 32'h1000, 32'h0, 32'h2, 0, 3, 0, 5, gd, gf, gb, gw);
      chk("lh_data", gd, 32'hFFFF8011);
      run_op(OP_LW, 32'h1000, 32'h0, 32'h1, 0, 1, 0, 1, gd, gf, gb, gw);
      chk("lw_mis_fault", gf, FAULT_MISALIGNED);
      chk("lw_mis_data", gd, 32'h0);
      run_op(OP_SH, 32'h2000, 32'h1234, 32'h1, 0, 0, 0, 1, gd, gf, gb, gw);
      chk("sh_mis_fault", gf, FAULT_MISALIGNED);
      run_op(OP_SB, 32'h2000, 32'h0000005A, 32'h1, 0, 0, 0, 2, gd, gf, gb, gw);
      chk("sb_be", gb, 4'b0010);
      run_op(OP_LW, 32'h2000, 32'h0, 32'h0, 1, 2, 0, 5, gd, gf, gb, gw);
      chk("lw_after_st", gd, 32'hABCD5A00);
      run_op(OP_SW, 32'h3010, 32'h12345678, 32'hFFFFFFF0, 0, 0, 0, 2, gd, gf, gb, gw);
      run_op(OP_LB, 32'h3000, 32'h0, 32'h1, 0, 1, 0, 3, gd, gf, gb, gw);
      chk("lb_sw_data", gd, 32'h00000056);
      run_op(OP_LUI, 32'h5555, 32'h0, 32'hABCDE000, 0, 0, 0, 1, gd, gf, gb, gw);
      chk("lui_data", gd, 32'hABCDE000);
      chk("lui_fault", gf, FAULT_NONE);
      run_op(OP_LW, 32'h1000, 32'h0, 32'h4, 0, -1, 0, 6, gd, gf, gb, gw);
      chk("timeout_fault", gf, FAULT_BUS_TIMEOUT);
      chk("timeout_data", gd, 32'h0);
      run_op(OP_LW, 32'h1000, 32'h0, 32'h4, 0, 4, 0, 6, gd, gf, gb, gw);
      chk("last_cycle_data", gd, 32'hDEADBEEF);
      chk("last_cycle_fault", gf, FAULT_NONE);

      @(negedge clk);
      req_exp = 1'b1; exp_addr = 32'h1004; exp_be = 4'hF; exp_we = 1'b0;
      req_valid = 1'b1; ls_op = OP_LW; rs1_data = 32'h1000; imm = 32'h4;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_seq_dreq", d_req_valid, 1);
      d_req_ready = 1'b1;
      @(negedge clk);
      d_req_ready = 1'b0;
      chk("rst_seq_busy", req_ready, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset("mid_wait");
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_resp_valid", resp_valid, 0);
         chk("post_rst_req_ready", req_ready, 1);
      end
      run_op(OP_LUI, 32'h0, 32'h0, 32'h00042000, 0, 0, 0, 1, gd, gf, gb, gw);
      chk("post_rst_lui", gd, 32'h00042000);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
